// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe
//   Signed three-stage pre-add / multiply / post-add slice with valid/ready
//   flow control, frame-based accumulation and optional saturation.
//
//   S1 registers the operands and controls, S2 holds the product
//   M = a * (d +/- b | b), and S3 holds p = Z +/- M, where Z is selected
//   from zero, c or the local accumulator.
//
// Ports
//   clk, rstn                  clock (rising edge), async active-low reset
//   in_valid/in_ready/in_last  input handshake and frame delimiter
//   a, b, d, c                 signed operands (AW, BW, DW, PW bits)
//   use_pre, pre_sub           pre-adder enable and d-b / d+b select
//   z_sel, post_sub            post-adder Z select (0 zero, 1 c, 2 acc, 3 zero)
//                              and Z-M / Z+M select
//   out_valid/out_ready        output handshake
//   p, overflow, out_last      result, per-beat overflow, delayed in_last
//   ovf_sticky, clr_sticky     sticky overflow flag and its synchronous clear
module dsp_mac_pipe #(
  parameter int AW       = 18,
  parameter int BW       = 18,
  parameter int DW       = 18,
  parameter int PW       = 48,
  parameter bit SATURATE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  input  logic signed [DW-1:0] d,
  input  logic signed [PW-1:0] c,
  input  logic                 use_pre,
  input  logic                 pre_sub,
  input  logic [1:0]           z_sel,
  input  logic                 post_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [PW-1:0] p,
  output logic                 overflow,
  output logic                 out_last,
  output logic                 ovf_sticky,
  input  logic                 clr_sticky
);

  localparam int QW = ((BW > DW) ? BW : DW) + 1;
  localparam int MW = AW + QW;
  localparam int EW = PW + 2;

  localparam logic signed [EW-1:0] E_MAX = {3'b000, {(PW-1){1'b1}}};
  localparam logic signed [EW-1:0] E_MIN = {3'b111, {(PW-1){1'b0}}};
  localparam logic signed [PW-1:0] P_MAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic signed [PW-1:0] P_MIN = {1'b1, {(PW-1){1'b0}}};

  if (AW + QW > PW) begin : g_width_check
    $error("dsp_mac_pipe: AW + max(BW,DW) + 1 must not exceed PW");
  end

  logic adv;

  // Stage 1 registers
  logic                 s1_valid;
  logic signed [AW-1:0] a1;
  logic signed [BW-1:0] b1;
  logic signed [DW-1:0] d1;
  logic signed [PW-1:0] c1;
  logic                 use_pre1, pre_sub1, post_sub1, last1;
  logic [1:0]           z_sel1;

  // Stage 2 registers
  logic                 s2_valid;
  logic signed [MW-1:0] m2;
  logic signed [PW-1:0] c2;
  logic                 post_sub2, last2;
  logic [1:0]           z_sel2;

  // Stage 3 state
  logic signed [PW-1:0] acc;

  // Combinational stage results
  logic signed [QW-1:0] b_q, d_q, q;
  logic signed [MW-1:0] a_m, q_m, m_n;
  logic signed [EW-1:0] z_e, m_e, sum;
  logic signed [PW-1:0] p_n;
  logic                 ovf_n;

  // A single advance enable for the whole pipe: any stall freezes every stage.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      a1        <= '0;
      b1        <= '0;
      d1        <= '0;
      c1        <= '0;
      use_pre1  <= 1'b0;
      pre_sub1  <= 1'b0;
      post_sub1 <= 1'b0;
      last1     <= 1'b0;
      z_sel1    <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      a1        <= a;
      b1        <= b;
      d1        <= d;
      c1        <= c;
      use_pre1  <= use_pre;
      pre_sub1  <= pre_sub;
      post_sub1 <= post_sub;
      last1     <= in_last;
      z_sel1    <= z_sel;
    end
  end

  // Pre-adder is one bit wider than its operands, so d +/- b never wraps.
  always_comb begin
    b_q = {{(QW-BW){b1[BW-1]}}, b1};
    d_q = {{(QW-DW){d1[DW-1]}}, d1};
    if (!use_pre1)    q = b_q;
    else if (pre_sub1) q = d_q - b_q;
    else              q = d_q + b_q;
    a_m = {{QW{a1[AW-1]}}, a1};
    q_m = {{AW{q[QW-1]}}, q};
    m_n = a_m * q_m;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid  <= 1'b0;
      m2        <= '0;
      c2        <= '0;
      post_sub2 <= 1'b0;
      last2     <= 1'b0;
      z_sel2    <= '0;
    end else if (adv) begin
      s2_valid  <= s1_valid;
      m2        <= m_n;
      c2        <= c1;
      post_sub2 <= post_sub1;
      last2     <= last1;
      z_sel2    <= z_sel1;
    end
  end

  // Post-add at PW+2 bits so that the true result is always representable
  // and the range check below is exact.
  always_comb begin
    case (z_sel2)
      2'd1:    z_e = {{2{c2[PW-1]}}, c2};
      2'd2:    z_e = {{2{acc[PW-1]}}, acc};
      default: z_e = '0;
    endcase
    m_e   = {{(EW-MW){m2[MW-1]}}, m2};
    sum   = post_sub2 ? (z_e - m_e) : (z_e + m_e);
    ovf_n = (sum > E_MAX) || (sum < E_MIN);
    if (SATURATE && ovf_n) p_n = sum[EW-1] ? P_MIN : P_MAX;
    else                   p_n = sum[PW-1:0];
  end

  // Output registers and accumulator change only when a real beat enters S3;
  // a frame-closing beat leaves acc at zero for the next frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      p         <= '0;
      overflow  <= 1'b0;
      out_last  <= 1'b0;
      acc       <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        p        <= p_n;
        overflow <= ovf_n;
        out_last <= last2;
        acc      <= last2 ? '0 : p_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                           ovf_sticky <= 1'b0;
    else if (clr_sticky)                 ovf_sticky <= 1'b0;
    else if (adv && s2_valid && ovf_n)   ovf_sticky <= 1'b1;
  end

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Directed testbench for dsp_mac_pipe: a saturating instance and a wrapping
// instance share the same stimulus; outputs are sampled on the falling edge.
module tb_dsp_mac_pipe;

  logic               clk = 1'b0;
  logic               rstn;
  logic               in_valid, in_last, use_pre, pre_sub, post_sub;
  logic               out_ready, clr_sticky;
  logic [1:0]         z_sel;
  logic signed [17:0] a, b, d;
  logic signed [47:0] c;

  logic               in_ready, out_valid, overflow, out_last, ovf_sticky;
  logic signed [47:0] p;
  logic               in_ready_w, out_valid_w, overflow_w, out_last_w, ovf_sticky_w;
  logic signed [47:0] p_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dsp_mac_pipe #(.AW(18), .BW(18), .DW(18), .PW(48), .SATURATE(1'b1)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .a(a), .b(b), .d(d), .c(c), .use_pre(use_pre),
    .pre_sub(pre_sub), .z_sel(z_sel), .post_sub(post_sub),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .overflow(overflow),
    .out_last(out_last), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky)
  );

  dsp_mac_pipe #(.AW(18), .BW(18), .DW(18), .PW(48), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_last(in_last), .a(a), .b(b), .d(d), .c(c), .use_pre(use_pre),
    .pre_sub(pre_sub), .z_sel(z_sel), .post_sub(post_sub),
    .out_valid(out_valid_w), .out_ready(out_ready), .p(p_w), .overflow(overflow_w),
    .out_last(out_last_w), .ovf_sticky(ovf_sticky_w), .clr_sticky(clr_sticky)
  );

  task automatic set_beat(input logic signed [17:0] ia, ib, id,
                          input logic signed [47:0] ic, input logic iu, ips,
                          input logic [1:0] iz, input logic ipost, ilast);
    a = ia; b = ib; d = id; c = ic; use_pre = iu; pre_sub = ips;
    z_sel = iz; post_sub = ipost; in_last = ilast;
  endtask

  // Sends one beat with out_ready high and waits (bounded) for its result.
  task automatic run_one(input logic signed [17:0] ia, ib, id,
                         input logic signed [47:0] ic, input logic iu, ips,
                         input logic [1:0] iz, input logic ipost, ilast,
                         output int lat);
    @(negedge clk);
    set_beat(ia, ib, id, ic, iu, ips, iz, ipost, ilast);
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b1; clr_sticky = 1'b0;
    set_beat('0, '0, '0, '0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (p !== 48'sd0) begin bad++; $display("FAIL reset_p got=%0d want=0", p); end
    total++; if (overflow !== 1'b0 || out_last !== 1'b0) begin bad++; $display("FAIL reset_flags got ovf=%b last=%b want 0 0", overflow, out_last); end
    total++; if (ovf_sticky !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%b want=0", ovf_sticky); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_preadd_mac;
    int lat;
    run_one(18'sd3, 18'sd4, 18'sd5, 48'sd10, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, lat);
    total++; if (out_valid !== 1'b1 || lat != 3) begin bad++; $display("FAIL mac_latency got valid=%b lat=%0d want valid=1 lat=3", out_valid, lat); end
    total++; if (p !== 48'sd37) begin bad++; $display("FAIL mac_p got=%0d want=37", p); end
    total++; if (overflow !== 1'b0 || out_last !== 1'b1) begin bad++; $display("FAIL mac_flags got ovf=%b last=%b want 0 1", overflow, out_last); end
  endtask

  task automatic test_frame_accum;
    logic signed [47:0] exp_p [5] = '{48'sd2, 48'sd6, 48'sd12, 48'sd20, 48'sd1};
    logic               exp_l [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int tx = 0;
    int rx = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && rx < 5; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        total++;
        if (p !== exp_p[rx] || out_last !== exp_l[rx]) begin
          bad++; $display("FAIL frame_beat%0d got p=%0d last=%b want p=%0d last=%b", rx, p, out_last, exp_p[rx], exp_l[rx]);
        end
        rx++;
      end
      if (tx < 4) begin
        set_beat(18'sd2, 18'(tx + 1), '0, '0, 1'b0, 1'b0, 2'd2, 1'b0, tx == 3);
        in_valid = 1'b1; tx++;
      end else if (tx == 4) begin
        set_beat(18'sd1, 18'sd1, '0, '0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1);
        in_valid = 1'b1; tx++;
      end else in_valid = 1'b0;
    end
    in_valid = 1'b0;
    total++; if (rx != 5) begin bad++; $display("FAIL frame_count got=%0d want=5", rx); end
  endtask

  task automatic test_stall;
    int tx = 0;
    int rx = 0;
    logic held = 1'b0;
    logic signed [47:0] held_p = '0;
    for (int cyc = 0; cyc < 60 && rx < 8; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 6 && cyc < 11);
      if (tx < 8) begin
        set_beat(18'(tx + 1), 18'sd1, '0, 48'(tx + 1), 1'b0, 1'b0, 2'd1, 1'b0, 1'b1);
        in_valid = 1'b1;
      end else in_valid = 1'b0;
      #1;
      if (out_valid && !out_ready) begin
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
        if (held) begin
          total++; if (p !== held_p) begin bad++; $display("FAIL stall_hold got=%0d want=%0d", p, held_p); end
        end
        held = 1'b1; held_p = p;
      end else held = 1'b0;
      if (out_valid && out_ready) begin
        total++;
        if (p !== 48'(2 * (rx + 1))) begin bad++; $display("FAIL stall_beat%0d got=%0d want=%0d", rx, p, 2 * (rx + 1)); end
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    total++; if (rx != 8 || tx != 8) begin bad++; $display("FAIL stall_count got rx=%0d tx=%0d want 8 8", rx, tx); end
    repeat (4) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_drain got valid=%b want=0", out_valid); end
  endtask

  task automatic test_saturate;
    int lat;
    logic signed [47:0] maxp = {1'b0, {47{1'b1}}};
    logic signed [47:0] minp = {1'b1, {47{1'b0}}};
    run_one(18'sd1, 18'sd1, '0, maxp, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, lat);
    total++; if (out_valid !== 1'b1 || p !== maxp || overflow !== 1'b1) begin bad++; $display("FAIL sat_p got p=%0d ovf=%b want p=%0d ovf=1", p, overflow, maxp); end
    total++; if (p_w !== minp || overflow_w !== 1'b1) begin bad++; $display("FAIL wrap_p got p=%0d ovf=%b want p=%0d ovf=1", p_w, overflow_w, minp); end
    total++; if (ovf_sticky !== 1'b1) begin bad++; $display("FAIL sticky_set got=%b want=1", ovf_sticky); end
    @(negedge clk);
    clr_sticky = 1'b1;
    @(negedge clk);
    clr_sticky = 1'b0;
    total++; if (ovf_sticky !== 1'b0) begin bad++; $display("FAIL sticky_clear got=%b want=0", ovf_sticky); end
  endtask

  task automatic test_presub_range;
    int lat;
    run_one(-18'sd1, 18'sd131071, -18'sd131072, '0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, lat);
    total++; if (out_valid !== 1'b1 || p !== 48'sd262143 || overflow !== 1'b0) begin bad++; $display("FAIL presub_p got p=%0d ovf=%b want p=262143 ovf=0", p, overflow); end
  endtask

  task automatic test_reset_midframe;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_beat(18'sd5, 18'sd5, '0, '0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0);
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midframe_inflight got valid=%b want=1", out_valid); end
    rstn = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || p !== 48'sd0) begin bad++; $display("FAIL midframe_reset got valid=%b p=%0d want 0 0", out_valid, p); end
    @(negedge clk);
    rstn = 1'b1;
    run_one(18'sd1, 18'sd7, '0, '0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, lat);
    total++; if (out_valid !== 1'b1 || p !== 48'sd7) begin bad++; $display("FAIL midframe_after got valid=%b p=%0d want 1 7", out_valid, p); end
  endtask

  initial begin
    test_reset;
    test_preadd_mac;
    test_frame_accum;
    test_stall;
    test_saturate;
    test_presub_range;
    test_reset_midframe;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
